// File: rtl/reggp_pkg.sv
// Shared constants and types for the reggp_sb register file / scoreboard.
// Optional write-through forwarding is enabled with REGGP_SB_BYPASS_EN.
package reggp_pkg;

    localparam int DATA_W_DFLT = 24;
    localparam int ADDR_W_DFLT = 4;
    localparam int NREGS       = 1 << ADDR_W_DFLT;

    typedef logic [ADDR_W_DFLT-1:0] reg_addr_t;
    typedef logic [DATA_W_DFLT-1:0] reg_word_t;

endpackage

// File: rtl/reggp_sb_busy.sv
// Per-register busy bits, reservation acceptance and outstanding-write count.
// Used by reggp_sb (REGGP_SB_BYPASS_EN only affects the top's read path).
module reggp_sb_busy
    import reggp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int NR     = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [NR-1:0]     busy_vec,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [NR-1:0]   r_busy;
    logic [ADDR_W:0] r_cnt;
    logic            w_rsv_ok;
    logic            w_inc;
    logic            w_dec;
    logic            w_same;
    logic [NR-1:0]   w_busy_nxt;
    logic [ADDR_W:0] w_cnt_nxt;

    always_comb begin
        w_same   = (waddr == rsv_addr);
        w_rsv_ok = rsv & (~r_busy[rsv_addr] | (we & w_same));
        w_inc    = w_rsv_ok & ~r_busy[rsv_addr];
        // A writeback retiring into an accepted re-reservation is a handover, not a drop
        w_dec    = we & r_busy[waddr] & ~(w_rsv_ok & w_same);
        w_busy_nxt = r_busy;
        if (we) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, w_inc}
                          - {{ADDR_W{1'b0}}, w_dec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign rsv_ok   = w_rsv_ok;
    assign busy_vec = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/reggp_sb.sv
// General-purpose register file with integrated scoreboard.
// Define REGGP_SB_BYPASS_EN for same-cycle writeback forwarding on reads.
module reggp_sb
    import reggp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        raddr1,
    input  logic [ADDR_W-1:0]        raddr2,
    output logic [DATA_W-1:0]        rdata1,
    output logic [DATA_W-1:0]        rdata2,
    output logic                     rbusy1,
    output logic                     rbusy2,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [(1<<ADDR_W)-1:0]   busy_vec,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NR = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NR];
    logic              w_fwd1;
    logic              w_fwd2;
    logic [NR-1:0]     w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

`ifdef REGGP_SB_BYPASS_EN
    assign w_fwd1 = we && (waddr == raddr1);
    assign w_fwd2 = we && (waddr == raddr2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign rdata1 = w_fwd1 ? wdata : r_regs[raddr1];
    assign rdata2 = w_fwd2 ? wdata : r_regs[raddr2];
    assign rbusy1 = w_busy[raddr1] & ~w_fwd1;
    assign rbusy2 = w_busy[raddr2] & ~w_fwd2;
    assign busy_vec = w_busy;

    reggp_sb_busy #(
        .ADDR_W (ADDR_W),
        .NR     (NR)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy_vec (w_busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_reggp_sb.sv
// Directed self-checking bench for reggp_sb (default and 32x32 builds).
// Expectations follow REGGP_SB_BYPASS_EN when it is defined.
module tb_reggp_sb;

`ifdef REGGP_SB_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  raddr1 = '0, raddr2 = '0, waddr = '0, rsv_addr = '0;
    logic [23:0] rdata1, rdata2, wdata = '0;
    logic        rbusy1, rbusy2, we = 1'b0, rsv = 1'b0, rsv_ok;
    logic [15:0] busy_vec;
    logic [4:0]  busy_cnt;

    logic [4:0]  p_raddr1 = '0, p_raddr2 = '0, p_waddr = '0, p_rsv_addr = '0;
    logic [31:0] p_rdata1, p_rdata2, p_wdata = '0;
    logic        p_rbusy1, p_rbusy2, p_we = 1'b0, p_rsv = 1'b0, p_rsv_ok;
    logic [31:0] p_busy_vec;
    logic [5:0]  p_busy_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reggp_sb dut (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    reggp_sb #(.DATA_W(32), .ADDR_W(5)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .raddr1(p_raddr1), .raddr2(p_raddr2),
        .rdata1(p_rdata1), .rdata2(p_rdata2),
        .rbusy1(p_rbusy1), .rbusy2(p_rbusy2),
        .we(p_we), .waddr(p_waddr), .wdata(p_wdata),
        .rsv(p_rsv), .rsv_addr(p_rsv_addr), .rsv_ok(p_rsv_ok),
        .busy_vec(p_busy_vec), .busy_cnt(p_busy_cnt)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [23:0] wd;
        logic        rsv;
        logic [3:0]  ra;
        logic [3:0]  rd;
        logic        ok;
        logic [23:0] d;
        logic        b;
        logic [15:0] vec;
        logic [4:0]  cnt;
    } vec_t;

    vec_t tv [15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0; wdata = '0; waddr = '0; rsv_addr = '0;
    endtask

    initial begin
        // {we, waddr, wdata, rsv, rsv_addr, raddr, ok, rdata, rbusy, vec', cnt'}
        tv[0]  = '{0, 0, 24'h0,      1, 3, 3, 1, 24'h0,      0, 16'h0008, 1};
        tv[1]  = '{0, 0, 24'h0,      0, 0, 3, 0, 24'h0,      1, 16'h0008, 1};
        tv[2]  = '{1, 3, 24'hABCDEF, 0, 0, 3, 0,
                   BP ? 24'hABCDEF : 24'h0, !BP, 16'h0000, 0};
        tv[3]  = '{0, 0, 24'h0,      0, 0, 3, 0, 24'hABCDEF, 0, 16'h0000, 0};
        tv[4]  = '{0, 0, 24'h0,      1, 4, 4, 1, 24'h0,      0, 16'h0010, 1};
        tv[5]  = '{0, 0, 24'h0,      1, 4, 0, 0, 24'h0,      0, 16'h0010, 1};
        tv[6]  = '{1, 4, 24'h111111, 1, 4, 0, 1, 24'h0,      0, 16'h0010, 1};
        tv[7]  = '{0, 0, 24'h0,      0, 0, 4, 0, 24'h111111, 1, 16'h0010, 1};
        tv[8]  = '{0, 0, 24'h0,      1, 2, 3, 1, 24'hABCDEF, 0, 16'h0014, 2};
        tv[9]  = '{1, 2, 24'h222222, 1, 1, 3, 1, 24'hABCDEF, 0, 16'h0012, 2};
        tv[10] = '{0, 0, 24'h0,      0, 0, 2, 0, 24'h222222, 0, 16'h0012, 2};
        tv[11] = '{1, 5, 24'h050505, 0, 0, 1, 0, 24'h0,      1, 16'h0012, 2};
        tv[12] = '{1, 1, 24'h010101, 1, 1, 5, 1, 24'h050505, 0, 16'h0012, 2};
        tv[13] = '{1, 1, 24'h0A0A0A, 0, 0, 4, 0, 24'h111111, 1, 16'h0010, 1};
        tv[14] = '{1, 4, 24'h444444, 0, 0, 2, 0, 24'h222222, 0, 16'h0000, 0};

        #2;
        chk("reset_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_vec", 64'(busy_vec), 64'd0);
        #10 rst_n = 1'b1;
        cyc();

        foreach (tv[k]) begin
            we = tv[k].we; waddr = tv[k].wa; wdata = tv[k].wd;
            rsv = tv[k].rsv; rsv_addr = tv[k].ra;
            raddr1 = tv[k].rd; raddr2 = tv[k].rd;
            #1;
            chk($sformatf("v%0d_rsv_ok", k), 64'(rsv_ok), 64'(tv[k].ok));
            chk($sformatf("v%0d_rdata1", k), 64'(rdata1), 64'(tv[k].d));
            chk($sformatf("v%0d_rdata2", k), 64'(rdata2), 64'(tv[k].d));
            chk($sformatf("v%0d_rbusy1", k), 64'(rbusy1), 64'(tv[k].b));
            chk($sformatf("v%0d_rbusy2", k), 64'(rbusy2), 64'(tv[k].b));
            cyc();
            chk($sformatf("v%0d_vec", k), 64'(busy_vec), 64'(tv[k].vec));
            chk($sformatf("v%0d_cnt", k), 64'(busy_cnt), 64'(tv[k].cnt));
        end
        idle();

        for (int i = 0; i < 16; i++) begin
            rsv = 1'b1; rsv_addr = 4'(i);
            #1;
            chk($sformatf("full_rsv_ok%0d", i), 64'(rsv_ok), 64'd1);
            cyc();
        end
        idle();
        chk("full_cnt", 64'(busy_cnt), 64'd16);
        chk("full_vec", 64'(busy_vec), 64'hFFFF);
        rsv = 1'b1; rsv_addr = 4'd9;
        #1;
        chk("full_waw_refuse", 64'(rsv_ok), 64'd0);
        cyc();
        chk("full_cnt_hold", 64'(busy_cnt), 64'd16);
        idle();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 24'h0F0000 + 24'(i);
            cyc();
            chk($sformatf("drain_cnt%0d", i), 64'(busy_cnt), 64'(15 - i));
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            raddr1 = 4'(i); raddr2 = 4'(15 - i);
            #1;
            chk($sformatf("rd1_r%0d", i), 64'(rdata1), 64'(24'h0F0000 + 24'(i)));
            chk($sformatf("rd2_r%0d", 15 - i), 64'(rdata2),
                64'(24'h0F0000 + 24'(15 - i)));
        end

        p_we = 1'b1; p_waddr = 5'd31; p_wdata = 32'hFFFFFFFF;
        cyc();
        p_we = 1'b0; p_raddr1 = 5'd31; p_raddr2 = 5'd31;
        p_rsv = 1'b1; p_rsv_addr = 5'd31;
        #1;
        chk("p32_rd1", 64'(p_rdata1), 64'hFFFFFFFF);
        chk("p32_rd2", 64'(p_rdata2), 64'hFFFFFFFF);
        chk("p32_rsv_ok", 64'(p_rsv_ok), 64'd1);
        cyc();
        p_rsv = 1'b0;
        chk("p32_vec", 64'(p_busy_vec), 64'h80000000);
        chk("p32_cnt", 64'(p_busy_cnt), 64'd1);
        chk("p32_rbusy1", 64'(p_rbusy1), 64'd1);

        we = 1'b1; waddr = 4'd5; wdata = 24'h123456;
        rsv = 1'b1; rsv_addr = 4'd7; raddr1 = 4'd5;
        cyc();
        idle();
        chk("pre_rst_rd5", 64'(rdata1), 64'h123456);
        chk("pre_rst_vec", 64'(busy_vec), 64'h0080);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd5", 64'(rdata1), 64'd0);
        chk("async_rst_vec", 64'(busy_vec), 64'd0);
        chk("async_rst_cnt", 64'(busy_cnt), 64'd0);
        chk("async_rst_p32", 64'(p_busy_cnt), 64'd0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        chk("post_rst_rd5", 64'(rdata1), 64'd0);
        chk("post_rst_vec", 64'(busy_vec), 64'd0);
        chk("post_rst_cnt", 64'(busy_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
